// File: rtl/round_sequencer_pkg.sv
// Shared encodings for the permutation round sequencer: FSM states, step IDs,
// memory-owner codes and default round count.
package round_sequencer_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LAUNCH  = 3'd1;
   localparam logic [2:0] ST_WAIT    = 3'd2;
   localparam logic [2:0] ST_ADVANCE = 3'd3;
   localparam logic [2:0] ST_FINISH  = 3'd4;

   localparam logic [2:0] STEP_THETA = 3'd0;
   localparam logic [2:0] STEP_RHO   = 3'd1;
   localparam logic [2:0] STEP_PI    = 3'd2;
   localparam logic [2:0] STEP_CHI   = 3'd3;
   localparam logic [2:0] STEP_IOTA  = 3'd4;

   localparam logic [2:0] HOST_OWNER     = 3'd7;
   localparam int         DEFAULT_ROUNDS = 24;
   localparam int         NUM_STEPS      = 5;

   function automatic logic [4:0] step_onehot(input logic [2:0] step);
      return 5'b00001 << step;
   endfunction

endpackage

// File: rtl/round_sequencer_counter.sv
// Loadable, enabled up-counter that saturates at TERM and flags terminal count.
module round_sequencer_counter #(
   parameter int         W    = 3,
   parameter logic [W-1:0] TERM = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_clr,
   input  logic         i_en,
   output logic [W-1:0] o_cnt,
   output logic         o_tc
);

   logic [W-1:0] r_cnt;

   // Saturating at TERM keeps the count from ever wrapping past the last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != TERM)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;
   assign o_tc  = (r_cnt == TERM);

endmodule

// File: rtl/round_sequencer.sv
// Sequences the five step engines through ROUNDS rounds and arbitrates the state memory.
//   state   | meaning
//   IDLE    | no job; host owns memory; start accepted here
//   LAUNCH  | one-cycle launch pulse to the current step engine
//   WAIT    | waiting for the current engine's completion strobe
//   ADVANCE | bump step, or wrap step and bump round, or finish
//   FINISH  | one-cycle done pulse, counters cleared on exit
module round_sequencer
   import round_sequencer_pkg::*;
#(
   parameter int ROUNDS = DEFAULT_ROUNDS,
   parameter int STEPS  = NUM_STEPS
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic [4:0] stepDone,
   output logic [4:0] stepStart,
   output logic [2:0] memOwner,
   output logic [4:0] round,
   output logic       busy,
   output logic       done,
   output logic       err
);

   logic [2:0] r_state;
   logic [2:0] w_next;
   logic       r_err;
   logic [2:0] w_step;
   logic [4:0] w_round;
   logic       w_step_tc;
   logic       w_round_tc;
   logic       w_accept;
   logic       w_abort;
   logic [4:0] w_onehot;
   logic       w_step_hit;
   logic       w_proto_err;
   logic       w_step_clr;
   logic       w_step_en;
   logic       w_round_clr;
   logic       w_round_en;
   logic       w_adv_wrap;

   assign w_accept    = (r_state == ST_IDLE) && start && !abort;
   assign w_abort     = (r_state != ST_IDLE) && abort;
   assign w_onehot    = step_onehot(w_step);
   assign w_step_hit  = |(stepDone & w_onehot);
   assign w_proto_err = (r_state == ST_WAIT) ? |(stepDone & ~w_onehot) : |stepDone;
   assign w_adv_wrap  = (r_state == ST_ADVANCE) && w_step_tc;

   // Step is left at its last value going into FINISH; FINISH clears both counters.
   assign w_step_clr  = w_accept || w_abort || (r_state == ST_FINISH) || (w_adv_wrap && !w_round_tc);
   assign w_step_en   = (r_state == ST_ADVANCE) && !w_step_tc && !w_abort;
   assign w_round_clr = w_accept || w_abort || (r_state == ST_FINISH);
   assign w_round_en  = w_adv_wrap && !w_round_tc && !w_abort;

   round_sequencer_counter #(.W(3), .TERM(3'(STEPS - 1))) u_step_cnt (
      .clk   (clk),
      .rst_n (rst),
      .i_clr (w_step_clr),
      .i_en  (w_step_en),
      .o_cnt (w_step),
      .o_tc  (w_step_tc)
   );

   round_sequencer_counter #(.W(5), .TERM(5'(ROUNDS - 1))) u_round_cnt (
      .clk   (clk),
      .rst_n (rst),
      .i_clr (w_round_clr),
      .i_en  (w_round_en),
      .o_cnt (w_round),
      .o_tc  (w_round_tc)
   );

   always_comb begin
      w_next = r_state;
      if (w_abort) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:    if (w_accept) w_next = ST_LAUNCH;
            ST_LAUNCH:  w_next = ST_WAIT;
            ST_WAIT:    if (w_step_hit) w_next = ST_ADVANCE;
            ST_ADVANCE: w_next = (w_step_tc && w_round_tc) ? ST_FINISH : ST_LAUNCH;
            ST_FINISH:  w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_err   <= (r_err && !w_accept) || w_proto_err;
      end
   end

   assign stepStart = (r_state == ST_LAUNCH) ? w_onehot : 5'b00000;
   assign memOwner  = ((r_state == ST_LAUNCH) || (r_state == ST_WAIT) || (r_state == ST_ADVANCE))
                      ? w_step : HOST_OWNER;
   assign round     = w_round;
   assign busy      = (r_state != ST_IDLE);
   assign done      = (r_state == ST_FINISH);
   assign err       = r_err;

endmodule

// File: tb/tb_round_sequencer.sv
// Scoreboard bench for round_sequencer with ROUNDS=2 and an echoing step-engine model.
module tb_round_sequencer;

   localparam int R = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [4:0] stepDone = 5'b0;
   logic [4:0] stepStart;
   logic [2:0] memOwner;
   logic [4:0] round;
   logic       busy;
   logic       done;
   logic       err;

   round_sequencer #(.ROUNDS(R), .STEPS(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .stepDone  (stepDone),
      .stepStart (stepStart),
      .memOwner  (memOwner),
      .round     (round),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] ss;
      logic       dn;
      logic [4:0] rnd;
      logic [2:0] own;
      logic       er;
      int         cyc;
   } ev_t;

   ev_t        exp_q[$];
   ev_t        mon_e;
   int         n_pass = 0;
   int         n_total = 0;
   int         cyc = 0;
   logic [4:0] hold_mask = 5'b0;
   logic [4:0] delay_mask = 5'b0;
   int         delay_cyc = 0;
   logic [4:0] eng_ss;
   int         eng_d;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every launch pulse or done pulse consumes one expected event.
   always @(negedge clk) begin
      if (rst && (stepStart != 5'b0 || done)) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_event: got stepStart=%0h done=%0b expected no event (t=%0t)",
                     stepStart, done, $time);
         end else begin
            mon_e = exp_q.pop_front();
            check("ev_stepStart", 32'(stepStart), 32'(mon_e.ss));
            check("ev_done", 32'(done), 32'(mon_e.dn));
            check("ev_memOwner", 32'(memOwner), 32'(mon_e.own));
            check("ev_err", 32'(err), 32'(mon_e.er));
            if (!mon_e.dn) check("ev_round", 32'(round), 32'(mon_e.rnd));
            if (mon_e.cyc >= 0) check("ev_cycle", 32'(cyc), 32'(mon_e.cyc));
         end
      end
   end

   // Step-engine model: echoes stepDone in the cycle after the launch, optionally delayed.
   always begin
      @(negedge clk);
      if (rst && stepStart != 5'b0 && (stepStart & hold_mask) == 5'b0) begin
         eng_ss = stepStart;
         eng_d  = ((stepStart & delay_mask) != 5'b0) ? delay_cyc : 0;
         @(posedge clk);
         repeat (eng_d) @(posedge clk);
         #1;
         if (busy) begin
            stepDone = eng_ss;
            @(posedge clk);
            #1;
            stepDone = 5'b0;
         end
      end
   end

   // Expected events for one job; dstep>4 means no delayed step, err_from is the launch
   // index from which err is expected high, n_ev limits how many launches are expected.
   task automatic push_job(input int base, input int dstep, input int dly, input bit chk,
                           input int err_from, input int n_ev);
      ev_t e;
      int  extra;
      for (int r = 0; r < R; r++) begin
         for (int s = 0; s < 5; s++) begin
            if (5 * r + s < n_ev) begin
               extra = (dstep <= 4) ? dly * (r + ((s > dstep) ? 1 : 0)) : 0;
               e.ss  = 5'(1 << s);
               e.dn  = 1'b0;
               e.rnd = 5'(r);
               e.own = 3'(s);
               e.er  = (5 * r + s >= err_from);
               e.cyc = chk ? base + 15 * r + 3 * s + extra : -1;
               exp_q.push_back(e);
            end
         end
      end
      if (n_ev >= 5 * R) begin
         extra = (dstep <= 4) ? dly * R : 0;
         e.ss  = 5'b0;
         e.dn  = 1'b1;
         e.rnd = 5'(R - 1);
         e.own = 3'd7;
         e.er  = (err_from <= 5 * R);
         e.cyc = chk ? base + 15 * R + extra : -1;
         exp_q.push_back(e);
      end
   endtask

   task automatic start_job(input int dstep, input int dly, input bit chk,
                            input int err_from, input int n_ev);
      @(negedge clk);
      push_job(cyc + 1, dstep, dly, chk, err_from, n_ev);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string name);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy && exp_q.size() == 0) return;
      end
      n_total++;
      $display("FAIL %s: got busy=%0b pending=%0d expected idle within %0d cycles",
               name, busy, exp_q.size(), budget);
      exp_q.delete();
   endtask

   task automatic wait_ss(input logic [4:0] ss, input logic [4:0] rnd, input int budget,
                          input string name, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (stepStart == ss && round == rnd) begin
            ok = 1'b1;
            return;
         end
      end
      n_total++;
      $display("FAIL %s: got no stepStart=%0h in round %0d expected within %0d cycles",
               name, ss, rnd, budget);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got simulation still running expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;

      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_memOwner", 32'(memOwner), 32'd7);
      check("rst_round", 32'(round), 32'd0);
      check("rst_stepStart", 32'(stepStart), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // abort together with start in Idle leaves the block idle
      abort = 1'b1;
      start = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      check("abort_start_idle_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("abort_start_idle_busy2", 32'(busy), 32'd0);

      // nominal job, plus a start pulse while busy that must not queue
      start_job(9, 0, 1'b1, 99, 10);
      repeat (7) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle(200, "job1_timeout");
      check("job1_err", 32'(err), 32'd0);
      check("job1_memOwner", 32'(memOwner), 32'd7);
      check("job1_round", 32'(round), 32'd0);
      repeat (40) @(negedge clk);
      check("busy_start_not_queued", 32'(busy), 32'd0);

      // step 2 delayed by ten cycles in each round
      delay_mask = 5'b00100;
      delay_cyc  = 10;
      start_job(2, 10, 1'b1, 99, 10);
      wait_ss(5'b00100, 5'd0, 50, "delay_launch_wait", ok);
      if (ok) begin
         for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            check("delay_memOwner", 32'(memOwner), 32'd2);
            check("delay_stepStart", 32'(stepStart), 32'd0);
         end
      end
      wait_idle(300, "delay_job_timeout");
      delay_mask = 5'b0;

      // wrong completion strobe while waiting on step 1
      hold_mask = 5'b00010;
      start_job(9, 0, 1'b0, 2, 10);
      wait_ss(5'b00010, 5'd0, 50, "err_launch_wait", ok);
      @(posedge clk);
      #1 stepDone = 5'b00001;
      @(posedge clk);
      #1 stepDone = 5'b00000;
      @(negedge clk);
      check("err_set", 32'(err), 32'd1);
      check("err_still_wait_owner", 32'(memOwner), 32'd1);
      check("err_still_busy", 32'(busy), 32'd1);
      repeat (3) @(negedge clk);
      check("err_held_owner", 32'(memOwner), 32'd1);
      @(posedge clk);
      #1 stepDone = 5'b00010;
      hold_mask = 5'b0;
      @(posedge clk);
      #1 stepDone = 5'b00000;
      wait_idle(200, "err_job_timeout");
      check("err_sticky_after_done", 32'(err), 32'd1);
      start_job(9, 0, 1'b1, 99, 10);
      wait_idle(200, "err_clear_job_timeout");
      check("err_cleared_by_start", 32'(err), 32'd0);

      // abort during round 1 step 3
      start_job(9, 0, 1'b1, 99, 9);
      wait_ss(5'b01000, 5'd1, 100, "abort_launch_wait", ok);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_memOwner", 32'(memOwner), 32'd7);
      check("abort_round", 32'(round), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_stepStart", 32'(stepStart), 32'd0);
      repeat (5) @(negedge clk);
      check("abort_stays_idle", 32'(busy), 32'd0);
      check("abort_err", 32'(err), 32'd0);
      start_job(9, 0, 1'b1, 99, 10);
      wait_idle(200, "restart_job_timeout");

      // asynchronous reset in the middle of Wait
      start_job(9, 0, 1'b1, 99, 2);
      wait_ss(5'b00010, 5'd0, 50, "reset_launch_wait", ok);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_memOwner", 32'(memOwner), 32'd7);
      check("arst_round", 32'(round), 32'd0);
      check("arst_stepStart", 32'(stepStart), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_err", 32'(err), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      check("arst_no_resume", 32'(busy), 32'd0);
      check("arst_queue_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/round_sequencer.md
ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 Parameter ROUNDS, default 24: number of permutation rounds per job, legal range 1..32.
REQ-002 Parameter STEPS, default 5: number of step engines sequenced per round (theta, rho, pi, chi, iota), fixed at 5.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, asynchronous and active-low.
REQ-005 Port start  input  1: host job request, sampled in Idle only.
REQ-006 Port abort  input  1: synchronous job cancel.
REQ-007 Port stepDone  input  5: one-hot completion strobes from the step engines; bit k belongs to step k.
REQ-008 Port stepStart  output  5: one-hot, one-cycle launch pulse to step engine k.
REQ-009 Port memOwner  output  3: 25-lane state memory grant; 0..4 selects step engine, 3'd7 selects host.
REQ-010 Port round  output  5: current round index, 0..ROUNDS-1.
REQ-011 Port busy  output  1: high whenever the state is not Idle.
REQ-012 Port done  output  1: one-cycle pulse when a job completes.
REQ-013 Port err  output  1: sticky protocol-error flag.

Function
REQ-014 The FSM SHALL have the states Idle, Launch, Wait, Advance and Finish, with a 3-bit step counter and a 5-bit round counter.
REQ-015 Idle: start=1 -> Launch with step=0 and round=0; otherwise remain in Idle.
REQ-016 Launch: drive stepStart[step]=1 for exactly one cycle, then -> Wait.
REQ-017 Wait: stepDone[step]=1 -> Advance; otherwise remain in Wait, with no timeout.
REQ-018 Advance with step<4: step+1 -> Launch.
REQ-019 Advance with step=4 and round<ROUNDS-1: step=0, round+1 -> Launch.
REQ-020 Advance with step=4 and round=ROUNDS-1 -> Finish.
REQ-021 Finish: done=1 for one cycle; step and round clear to 0 -> Idle.
REQ-022 memOwner SHALL equal step in Launch, Wait and Advance, and 3'd7 in Idle and Finish; it changes only on state or step transitions.
REQ-023 Minimum cost SHALL be 3 cycles per step (engine returns stepDone in the cycle after stepStart), giving done in cycle 15*ROUNDS+1, counting the first Launch cycle as cycle 1.
REQ-024 A start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-025 In Wait, any stepDone bit other than bit step SHALL set err and be otherwise ignored.
REQ-026 In any state other than Wait, any nonzero stepDone SHALL set err and be otherwise ignored.
REQ-027 err SHALL clear only on reset or on the next accepted start.
REQ-028 abort=1 in any non-Idle state SHALL go -> Idle on the next edge, clear step and round, suppress done and stepStart, and set memOwner=7; abort has priority over all other transitions.
REQ-029 abort in Idle SHALL have no effect, and abort and start sampled together in Idle SHALL leave the block in Idle.
REQ-030 The round counter SHALL never wrap: ROUNDS-1 is terminal.

Reset
REQ-031 rst=0 SHALL asynchronously force: state Idle, step=0, round=0, stepStart=0, memOwner=7, busy=0, done=0, err=0.
REQ-032 Reset asserted mid-job SHALL abandon the job without a done pulse; the block resumes in Idle one edge after rst returns high.

Structure
REQ-033 A shared package SHALL hold the state encoding (Idle=0, Launch=1, Wait=2, Advance=3, Finish=4), the step IDs THETA..IOTA=0..4, HOST_OWNER=3'd7, and the default ROUNDS.
REQ-034 One sub-module SHALL be used: the step/round counter pair as loadable, enabled counters, with a terminal-count output, in the codebase's existing counter style.
REQ-035 All outputs SHALL be decoded from state and counters: Moore only, no combinational input-to-output paths.

Verification
REQ-036 ROUNDS=2, engines echo stepDone one cycle after stepStart, start pulse -> stepStart cycles through 1,2,4,8,16 twice; done high in cycle 31; round goes 0 then 1; err=0.
REQ-037 Step 2 delays stepDone by 10 cycles -> Wait holds, memOwner=2 throughout, stepStart stays 0; then Advance -> Launch of step 3.
REQ-038 In Wait on step 1, stepDone=5'b00001 -> err=1 and the FSM stays in Wait; later stepDone=5'b00010 advances; err stays 1 until the next start.
REQ-039 abort during round 1 step 3 -> next cycle busy=0, memOwner=7, round=0, no done; a following start restarts from step 0, round 0.
REQ-040 rst low mid-Wait -> all outputs at reset values immediately, without waiting for a clock edge; start during busy causes no second job.
